// File: rtl/apply_ab.sv
// Guided-filter reader stage: streams a/b coefficients with the guide image and writes q = ((a*I)>>7)+b.
// Optional clamping of the result to 0..255 is enabled by defining APPLY_AB_SAT_EN.
module apply_ab #(
    parameter int unsigned N_PIX  = 63000,
    parameter int unsigned RD_LAT = 1
) (
    input  logic        iCLK,
    input  logic        iRST_N,
    input  logic        ena,
    output logic        done,
    output logic [15:0] iAddrR,
    input  logic [15:0] oDataA,
    input  logic [15:0] oDataB,
    input  logic [15:0] oDataI,
    output logic        wrenQ,
    output logic [15:0] iAddrQ,
    output logic [15:0] iDataQ
);

    localparam int unsigned AW = 16;
    localparam int unsigned PW = 24;
    localparam int unsigned SW = 18;
    localparam int unsigned QW = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [AW-1:0]   addr_nxt;
    logic            done_nxt;

    logic [RD_LAT-1:0] vld;
    logic [AW-1:0]     adly [RD_LAT];
    logic              issue;

    logic [PW-1:0]        prod;
    logic signed [SW-1:0] sum;
    logic [QW-1:0]        res;

    // State and read-address register
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            state  <= IDLE;
            iAddrR <= '0;
            done   <= 1'b0;
        end else begin
            state  <= state_nxt;
            iAddrR <= addr_nxt;
            done   <= done_nxt;
        end
    end

    // Next-state, next read address and done pulse
    always_comb begin
        state_nxt = state;
        addr_nxt  = '0;
        done_nxt  = 1'b0;
        case (state)
            IDLE: begin
                if (ena) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (iAddrR == AW'(N_PIX - 1)) begin
                    state_nxt = DRAIN;
                end else begin
                    addr_nxt = iAddrR + AW'(1);
                end
            end
            DRAIN: begin
                if (vld == '0) begin
                    state_nxt = DONE;
                    done_nxt  = 1'b1;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign issue = (state == RUN);

    // Valid and address delay lines matching the source RAM latency
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            vld <= '0;
            for (int i = 0; i < int'(RD_LAT); i++) begin
                adly[i] <= '0;
            end
        end else begin
            vld[0]  <= issue;
            adly[0] <= iAddrR;
            for (int i = 1; i < int'(RD_LAT); i++) begin
                vld[i]  <= vld[i-1];
                adly[i] <= adly[i-1];
            end
        end
    end

    assign prod = {8'd0, oDataA} * {16'd0, oDataI[7:0]};
    assign sum  = $signed({1'b0, prod[PW-1:7]}) + $signed({{2{oDataB[15]}}, oDataB});

`ifdef APPLY_AB_SAT_EN
    always_comb begin
        res = sum[QW-1:0];
        if (sum[SW-1]) begin
            res = '0;
        end else if (sum > 18'sd255) begin
            res = '1;
        end
    end

    logic unused_bits;
    assign unused_bits = ^{oDataI[15:8], prod[6:0]};
`else
    assign res = sum[QW-1:0];

    logic unused_bits;
    assign unused_bits = ^{oDataI[15:8], prod[6:0], sum[SW-1:QW]};
`endif

    // Output write port; data and address are forced to zero between writes
    always_ff @(posedge iCLK) begin
        if (!iRST_N) begin
            wrenQ  <= 1'b0;
            iAddrQ <= '0;
            iDataQ <= '0;
        end else begin
            wrenQ  <= vld[RD_LAT-1];
            iAddrQ <= vld[RD_LAT-1] ? adly[RD_LAT-1] : '0;
            iDataQ <= vld[RD_LAT-1] ? {8'd0, res} : '0;
        end
    end

endmodule

// File: tb/tb_apply_ab.sv
// Self-checking bench for apply_ab: behavioural RAMs, arithmetic reference model, directed and random passes.
module tb_apply_ab;

    localparam int N      = 1200;
    localparam int RD_LAT = 1;

    logic        clk;
    logic        rst_n;
    logic        ena;
    logic        done;
    logic [15:0] addr_r;
    logic [15:0] data_a;
    logic [15:0] data_b;
    logic [15:0] data_i;
    logic        wren;
    logic [15:0] addr_q;
    logic [15:0] data_q;

    logic [15:0] a_mem [N];
    logic [15:0] b_mem [N];
    logic [15:0] i_mem [N];
    logic [15:0] pa [RD_LAT];
    logic [15:0] pb [RD_LAT];
    logic [15:0] pi [RD_LAT];

    int n_cmp = 0;
    int n_err = 0;

    apply_ab #(.N_PIX(N), .RD_LAT(RD_LAT)) dut (
        .iCLK   (clk),
        .iRST_N (rst_n),
        .ena    (ena),
        .done   (done),
        .iAddrR (addr_r),
        .oDataA (data_a),
        .oDataB (data_b),
        .oDataI (data_i),
        .wrenQ  (wren),
        .iAddrQ (addr_q),
        .iDataQ (data_q)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Source RAMs with RD_LAT cycles from address to data
    always @(posedge clk) begin
        pa[0] <= a_mem[addr_r];
        pb[0] <= b_mem[addr_r];
        pi[0] <= i_mem[addr_r];
        for (int i = 1; i < RD_LAT; i++) begin
            pa[i] <= pa[i-1];
            pb[i] <= pb[i-1];
            pi[i] <= pi[i-1];
        end
    end
    assign data_a = pa[RD_LAT-1];
    assign data_b = pb[RD_LAT-1];
    assign data_i = pi[RD_LAT-1];

    // q from the arithmetic rules: 18-bit signed sum, then clamp or modulo-256
    function automatic int ref_q(input int unsigned a, input int unsigned b, input int unsigned i);
        int s;
        s = int'((a * (i % 256)) / 128) + ((b >= 32768) ? int'(b) - 65536 : int'(b));
        s = ((s % 262144) + 262144) % 262144;
        if (s >= 131072) s = s - 262144;
`ifdef APPLY_AB_SAT_EN
        if (s < 0) return 0;
        if (s > 255) return 255;
        return s;
`else
        return ((s % 256) + 256) % 256;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int k = 0; k < N; k++) begin
            case (mode)
                0: begin a_mem[k] = 16'd128; b_mem[k] = 16'd0;      i_mem[k] = 16'(k % 256); end
                1: begin a_mem[k] = 16'd64;  b_mem[k] = 16'd10;     i_mem[k] = 16'd200;      end
                2: begin a_mem[k] = 16'd128; b_mem[k] = 16'd20;     i_mem[k] = 16'd250;      end
                3: begin a_mem[k] = 16'd128; b_mem[k] = 16'hFFCE;   i_mem[k] = 16'd30;       end
                default: begin
                    if ($urandom_range(1, 0) == 0) begin
                        a_mem[k] = 16'($urandom_range(300, 0));
                        b_mem[k] = 16'(int'($urandom_range(600, 0)) - 300);
                    end else begin
                        a_mem[k] = 16'($urandom);
                        b_mem[k] = 16'($urandom);
                    end
                    i_mem[k] = 16'($urandom);
                end
            endcase
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_done"}, 32'(done), 0);
        chk({tag, "_wren"}, 32'(wren), 0);
        chk({tag, "_rd_addr"}, 32'(addr_r), 0);
        chk({tag, "_wr_addr"}, 32'(addr_q), 0);
        chk({tag, "_wr_data"}, 32'(data_q), 0);
    endtask

    // One pass: ena pulse, then every cycle C1+n checked against the expected schedule
    task automatic run_pass(input bit poke, input bit hold, input int abort_at);
        int k;
        @(negedge clk);
        ena = 1'b1;
        for (int n = 0; n <= N + RD_LAT + 1; n++) begin
            @(negedge clk);
            chk("rd_addr", 32'(addr_r), (n < N) ? n : 0);
            chk("wren", 32'(wren), (n >= RD_LAT + 1 && n <= N + RD_LAT) ? 1 : 0);
            chk("done", 32'(done), (n == N + RD_LAT + 1) ? 1 : 0);
            if (n >= RD_LAT + 1 && n <= N + RD_LAT) begin
                k = n - RD_LAT - 1;
                chk("wr_addr", 32'(addr_q), k);
                chk("wr_data", 32'(data_q), ref_q(a_mem[k], b_mem[k], i_mem[k]));
            end else begin
                chk("data_idle", 32'(data_q), 0);
            end
            if (n == abort_at) begin
                rst_n = 1'b0;
                ena   = 1'b0;
                break;
            end
            ena = hold || (poke && n == 50);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        ena   = 1'b0;
        fill(0);
        repeat (3) @(negedge clk);
        chk_quiet("reset");
        rst_n = 1'b1;

        // Identity with a stray ena pulse during RUN
        run_pass(1'b1, 1'b0, -1);
        repeat (3) begin
            @(negedge clk);
            chk_quiet("idle");
        end

        fill(1);
        run_pass(1'b0, 1'b0, -1);
        fill(2);
        run_pass(1'b0, 1'b0, -1);
        fill(3);
        run_pass(1'b0, 1'b0, -1);

        // ena held high: back in IDLE, then a new pass starts
        fill(4);
        run_pass(1'b0, 1'b1, -1);
        @(negedge clk);
        chk_quiet("reidle");
        @(negedge clk);
        chk("restart_addr0", 32'(addr_r), 0);
        @(negedge clk);
        chk("restart_addr1", 32'(addr_r), 1);
        rst_n = 1'b0;
        ena   = 1'b0;
        @(negedge clk);
        chk_quiet("rst_after_restart");
        rst_n = 1'b1;

        // Reset mid-RUN at address 1000, then a full pass on the same data
        fill(4);
        run_pass(1'b0, 1'b0, 1000);
        @(negedge clk);
        chk_quiet("midrun_rst");
        @(negedge clk);
        chk_quiet("midrun_rst_hold");
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk_quiet("post_rst");
        end
        run_pass(1'b0, 1'b0, -1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
